// File: rtl/forward_unit_pkg.sv
// Shared widths and the forwarding-source encoding for the operand forwarding unit.
package forward_unit_pkg;

    localparam int DW = 128;
    localparam int RW = 4;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_S3 = 2'b01,
        FWD_S4 = 2'b10
    } fwd_src_t;

endpackage

// File: rtl/forward_unit_fwd_mux.sv
// Per-operand forwarding selector: picks the newest matching producer result,
// falling back to the register-file value.
module fwd_mux
    import forward_unit_pkg::*;
#(
    parameter int DW = forward_unit_pkg::DW,
    parameter int RW = forward_unit_pkg::RW
) (
    input  logic [RW-1:0] regIdx_i,
    input  logic          eligible_i,
    input  logic          vf1_i,
    input  logic          vf2_i,
    input  logic [RW-1:0] destR3_i,
    input  logic [DW-1:0] res3_i,
    input  logic          vf3_i,
    input  logic [RW-1:0] destR4_i,
    input  logic [DW-1:0] res4_i,
    input  logic [DW-1:0] rfData_i,
    output logic [DW-1:0] data_o,
    output fwd_src_t      src_o
);

    logic hit3;
    logic hit4;

    // A producer only matches when it writes the same register file the consumer reads.
    assign hit3 = eligible_i && (regIdx_i == destR3_i) && (vf2_i == vf1_i);
    assign hit4 = eligible_i && (regIdx_i == destR4_i) && (vf3_i == vf1_i);

    always_comb begin
        data_o = rfData_i;
        src_o  = FWD_RF;
        if (hit3) begin
            data_o = res3_i;
            src_o  = FWD_S3;
        end else if (hit4) begin
            data_o = res4_i;
            src_o  = FWD_S4;
        end
    end

endmodule

// File: rtl/forward_unit.sv
// Operand forwarding unit: combinational bypass of operands 2 and 3, with the
// chosen source code registered one cycle later for downstream bookkeeping.
module forward_unit
    import forward_unit_pkg::*;
#(
    parameter int DW = forward_unit_pkg::DW,
    parameter int RW = forward_unit_pkg::RW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] R2res1,
    input  logic [DW-1:0] R3res1,
    input  logic [RW-1:0] R2_2,
    input  logic [RW-1:0] R3_2,
    input  logic [1:0]    ExtndSel1,
    input  logic          VF1,
    input  logic          VF2,
    input  logic [RW-1:0] DestR_3,
    input  logic [DW-1:0] Res,
    input  logic          VF3,
    input  logic [RW-1:0] DestR_4,
    input  logic [DW-1:0] Res1,
    output logic [DW-1:0] R2res2,
    output logic [DW-1:0] R3res2,
    output logic [1:0]    FwdSel2,
    output logic [1:0]    FwdSel3
);

    logic     eligible2;
    logic     eligible3;
    fwd_src_t fwdSel2_d;
    fwd_src_t fwdSel3_d;
    fwd_src_t fwdSel2_q;
    fwd_src_t fwdSel3_q;

    // A set ExtndSel1 bit marks that operand as an immediate/non-register value.
    assign eligible2 = ~ExtndSel1[1];
    assign eligible3 = ~ExtndSel1[0];

    fwd_mux #(.DW(DW), .RW(RW)) u_mux2 (
        .regIdx_i   (R2_2),
        .eligible_i (eligible2),
        .vf1_i      (VF1),
        .vf2_i      (VF2),
        .destR3_i   (DestR_3),
        .res3_i     (Res),
        .vf3_i      (VF3),
        .destR4_i   (DestR_4),
        .res4_i     (Res1),
        .rfData_i   (R2res1),
        .data_o     (R2res2),
        .src_o      (fwdSel2_d)
    );

    fwd_mux #(.DW(DW), .RW(RW)) u_mux3 (
        .regIdx_i   (R3_2),
        .eligible_i (eligible3),
        .vf1_i      (VF1),
        .vf2_i      (VF2),
        .destR3_i   (DestR_3),
        .res3_i     (Res),
        .vf3_i      (VF3),
        .destR4_i   (DestR_4),
        .res4_i     (Res1),
        .rfData_i   (R3res1),
        .data_o     (R3res2),
        .src_o      (fwdSel3_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fwdSel2_q <= FWD_RF;
            fwdSel3_q <= FWD_RF;
        end else begin
            fwdSel2_q <= fwdSel2_d;
            fwdSel3_q <= fwdSel3_d;
        end
    end

    assign FwdSel2 = fwdSel2_q;
    assign FwdSel3 = fwdSel3_q;

endmodule

// File: tb/tb_forward_unit.sv
// Bench for forward_unit: directed vector table, reset corner cases and a
// randomized run against a rule-level reference model.
module tb_forward_unit;

    localparam int DW = 128;
    localparam int RW = 4;

    typedef struct {
        logic [1:0]    ext;
        logic          vf1;
        logic          vf2;
        logic          vf3;
        logic [RW-1:0] r2;
        logic [RW-1:0] r3;
        logic [RW-1:0] d3;
        logic [RW-1:0] d4;
        logic [DW-1:0] r2res1;
        logic [DW-1:0] r3res1;
        logic [DW-1:0] res;
        logic [DW-1:0] res1;
        logic [DW-1:0] expR2;
        logic [DW-1:0] expR3;
        logic [1:0]    expSel2;
        logic [1:0]    expSel3;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] R2res1, R3res1, Res, Res1;
    logic [RW-1:0] R2_2, R3_2, DestR_3, DestR_4;
    logic [1:0]    ExtndSel1;
    logic          VF1, VF2, VF3;
    logic [DW-1:0] R2res2, R3res2;
    logic [1:0]    FwdSel2, FwdSel3;

    int checks = 0;
    int errors = 0;

    forward_unit #(.DW(DW), .RW(RW)) dut (
        .clk       (clk),
        .rst       (rst),
        .R2res1    (R2res1),
        .R3res1    (R3res1),
        .R2_2      (R2_2),
        .R3_2      (R3_2),
        .ExtndSel1 (ExtndSel1),
        .VF1       (VF1),
        .VF2       (VF2),
        .DestR_3   (DestR_3),
        .Res       (Res),
        .VF3       (VF3),
        .DestR_4   (DestR_4),
        .Res1      (Res1),
        .R2res2    (R2res2),
        .R3res2    (R3res2),
        .FwdSel2   (FwdSel2),
        .FwdSel3   (FwdSel3)
    );

    always #5 clk = ~clk;

    function automatic vec_t defaults();
        vec_t v;
        v.ext = 2'b00; v.vf1 = 1'b0; v.vf2 = 1'b0; v.vf3 = 1'b0;
        v.r2 = 4'd5; v.r3 = 4'd6; v.d3 = 4'd5; v.d4 = 4'd6;
        v.r2res1 = 'h10; v.r3res1 = 'h64; v.res = 'h15; v.res1 = 'h16;
        v.expR2 = '0; v.expR3 = '0; v.expSel2 = 2'b00; v.expSel3 = 2'b00;
        return v;
    endfunction

    // Reference: apply the forwarding rules for one operand directly.
    function automatic void refOperand(input logic notReg, input logic [RW-1:0] idx,
                                       input vec_t v, input logic [DW-1:0] rf,
                                       output logic [DW-1:0] data, output logic [1:0] src);
        if (!notReg && idx == v.d3 && v.vf2 == v.vf1) begin
            data = v.res;  src = 2'd1;
        end else if (!notReg && idx == v.d4 && v.vf3 == v.vf1) begin
            data = v.res1; src = 2'd2;
        end else begin
            data = rf;     src = 2'd0;
        end
    endfunction

    task automatic applyStimulus(input vec_t v);
        ExtndSel1 = v.ext; VF1 = v.vf1; VF2 = v.vf2; VF3 = v.vf3;
        R2_2 = v.r2; R3_2 = v.r3; DestR_3 = v.d3; DestR_4 = v.d4;
        R2res1 = v.r2res1; R3res1 = v.r3res1; Res = v.res; Res1 = v.res1;
    endtask

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive a vector, check the bypass immediately, then the registered codes after one edge.
    task automatic runVector(input string tag, input vec_t v, input logic rstVal);
        applyStimulus(v);
        rst = rstVal;
        #1;
        checkOutput({tag, " R2res2"}, R2res2, v.expR2);
        checkOutput({tag, " R3res2"}, R3res2, v.expR3);
        @(posedge clk);
        #1;
        checkOutput({tag, " FwdSel2"}, {126'd0, FwdSel2}, {126'd0, rstVal ? 2'b00 : v.expSel2});
        checkOutput({tag, " FwdSel3"}, {126'd0, FwdSel3}, {126'd0, rstVal ? 2'b00 : v.expSel3});
    endtask

    vec_t tbl[10];

    initial begin
        vec_t v;
        logic [DW-1:0] d2, d3x;
        logic [1:0]    s2, s3;

        for (int i = 0; i < 10; i++) tbl[i] = defaults();
        tbl[0].ext = 2'b11; tbl[0].expR2 = 'h10; tbl[0].expR3 = 'h64; tbl[0].expSel2 = 2'd0; tbl[0].expSel3 = 2'd0;
        tbl[1].ext = 2'b01; tbl[1].expR2 = 'h15; tbl[1].expR3 = 'h64; tbl[1].expSel2 = 2'd1; tbl[1].expSel3 = 2'd0;
        tbl[2].ext = 2'b00; tbl[2].expR2 = 'h15; tbl[2].expR3 = 'h16; tbl[2].expSel2 = 2'd1; tbl[2].expSel3 = 2'd2;
        tbl[3].d3 = 4'd8;   tbl[3].expR2 = 'h10; tbl[3].expR3 = 'h16; tbl[3].expSel2 = 2'd0; tbl[3].expSel3 = 2'd2;
        tbl[4].d3 = 4'd8;   tbl[4].d4 = 4'd0;
        tbl[4].expR2 = 'h10; tbl[4].expR3 = 'h64; tbl[4].expSel2 = 2'd0; tbl[4].expSel3 = 2'd0;
        tbl[5].d4 = 4'd5;   tbl[5].expR2 = 'h15; tbl[5].expR3 = 'h64; tbl[5].expSel2 = 2'd1; tbl[5].expSel3 = 2'd0;
        tbl[6].d3 = 4'd8;   tbl[6].d4 = 4'd5;
        tbl[6].expR2 = 'h16; tbl[6].expR3 = 'h64; tbl[6].expSel2 = 2'd2; tbl[6].expSel3 = 2'd0;
        tbl[7].vf1 = 1'b1;  tbl[7].expR2 = 'h10; tbl[7].expR3 = 'h64; tbl[7].expSel2 = 2'd0; tbl[7].expSel3 = 2'd0;
        tbl[8].ext = 2'b10; tbl[8].expR2 = 'h10; tbl[8].expR3 = 'h16; tbl[8].expSel2 = 2'd0; tbl[8].expSel3 = 2'd2;
        tbl[9].r2 = 4'd0;   tbl[9].r3 = 4'd0; tbl[9].d3 = 4'd0;
        tbl[9].expR2 = 'h15; tbl[9].expR3 = 'h15; tbl[9].expSel2 = 2'd1; tbl[9].expSel3 = 2'd1;

        // Reset state: forwarding-active inputs, codes must still read 00.
        applyStimulus(tbl[2]);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset FwdSel2", {126'd0, FwdSel2}, '0);
        checkOutput("reset FwdSel3", {126'd0, FwdSel3}, '0);

        for (int i = 0; i < 10; i++) runVector($sformatf("vec%0d", i), tbl[i], 1'b0);

        // Mid-run reset: bypass stays live, codes clear, then resume on the first free edge.
        runVector("midrst", tbl[2], 1'b1);
        runVector("resume", tbl[2], 1'b0);
        runVector("midrst6", tbl[6], 1'b1);
        runVector("resume6", tbl[6], 1'b0);

        for (int n = 0; n < 300; n++) begin
            v = defaults();
            v.ext = 2'($urandom_range(0, 3));
            v.vf1 = 1'($urandom); v.vf2 = 1'($urandom); v.vf3 = 1'($urandom);
            v.r2 = 4'($urandom_range(0, 3)); v.r3 = 4'($urandom_range(0, 3));
            v.d3 = 4'($urandom_range(0, 3)); v.d4 = 4'($urandom_range(0, 3));
            if (n % 16 == 15) v.r2 = 4'($urandom_range(0, 15));
            v.r2res1 = {$urandom, $urandom, $urandom, $urandom};
            v.r3res1 = {$urandom, $urandom, $urandom, $urandom};
            v.res    = {$urandom, $urandom, $urandom, $urandom};
            v.res1   = {$urandom, $urandom, $urandom, $urandom};
            refOperand(v.ext[1], v.r2, v, v.r2res1, d2, s2);
            refOperand(v.ext[0], v.r3, v, v.r3res1, d3x, s3);
            v.expR2 = d2; v.expR3 = d3x; v.expSel2 = s2; v.expSel3 = s3;
            runVector($sformatf("rnd%0d", n), v, ($urandom_range(0, 9) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
